// File: rtl/conv3d_pkg.sv
// Shared definitions for the 3D convolution datapath: default widths,
// tap-count helper, saturation helper and the output entry layout.
package conv3d_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ACC_W  = 48;

  typedef struct packed {
    logic                  last;
    logic [DEF_DATA_W-1:0] data;
  } vox_entry_t;

  typedef struct packed {
    logic                  ovf;
    logic [DEF_DATA_W-1:0] value;
  } sat_result_t;

  function automatic int calc_taps(input int kernel, input int in_ch);
    return kernel * kernel * kernel * in_ch;
  endfunction

  // Clamps a wide signed sum to data_w bits; the low data_w bits of value hold the result.
  function automatic sat_result_t sat_to_data(input logic signed [DEF_ACC_W-1:0] sum,
                                              input int data_w);
    logic signed [DEF_ACC_W-1:0] one;
    logic signed [DEF_ACC_W-1:0] max_v;
    logic signed [DEF_ACC_W-1:0] min_v;
    sat_result_t r;
    one   = {{(DEF_ACC_W-1){1'b0}}, 1'b1};
    max_v = (one <<< (data_w - 1)) - one;
    min_v = ~max_v;
    r.ovf   = 1'b0;
    r.value = sum[DEF_DATA_W-1:0];
    if (sum > max_v) begin
      r.ovf   = 1'b1;
      r.value = max_v[DEF_DATA_W-1:0];
    end else if (sum < min_v) begin
      r.ovf   = 1'b1;
      r.value = min_v[DEF_DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/conv3d_skid_fifo2.sv
// Two-entry valid/ready buffer with a registered head; the head keeps its
// last value while empty so downstream sees stable data.
module conv3d_skid_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  // Handshake: a transfer happens on a side only when its valid and ready are both high at clk.
  logic [1:0]   count;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         push;
  logic         pop;

  assign pop_valid  = (count != 2'd0);
  assign pop        = pop_valid && pop_ready;
  assign push_ready = (count != 2'd2) || pop;
  assign push       = push_valid && push_ready;
  assign pop_data   = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head  <= push_data;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= push_data;
          end else if (push) begin
            tail  <= push_data;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head <= tail;
            if (push) tail <= push_data;
            else      count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/conv3d_tap_accumulator.sv
// Sums KERNEL^3*IN_CH signed tap products plus a bias per output voxel,
// saturates to DATA_W and buffers results behind a 2-entry output FIFO.
module conv3d_tap_accumulator
  import conv3d_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int KERNEL  = 3,
  parameter int IN_CH   = 3,
  parameter int OUT_VOX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] prod_data,
  input  logic [DATA_W-1:0] bias_data,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] output_data,
  output logic              last_out,
  output logic              sat_flag
);

  localparam int TAPS    = calc_taps(KERNEL, IN_CH);
  localparam int TAP_W   = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int VOX_W   = (OUT_VOX > 1) ? $clog2(OUT_VOX) : 1;
  localparam int ENTRY_W = DATA_W + 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
  localparam logic [VOX_W-1:0] LAST_VOX = VOX_W'(OUT_VOX - 1);

  logic [TAP_W-1:0]            tap_cnt;
  logic [VOX_W-1:0]            vox_cnt;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     prod_ext;
  logic signed [ACC_W-1:0]     bias_ext;
  logic signed [ACC_W-1:0]     sum;
  logic signed [DEF_ACC_W-1:0] sum_wide;
  sat_result_t                 sat_res;
  logic                        is_first;
  logic                        is_last;
  logic                        accept;
  logic                        push_valid;
  logic                        push_ready;
  logic [ENTRY_W-1:0]          push_entry;
  logic [ENTRY_W-1:0]          head_entry;

  assign is_first = (tap_cnt == '0);
  assign is_last  = (tap_cnt == LAST_TAP);
  assign prod_ext = {{(ACC_W-DATA_W){prod_data[DATA_W-1]}}, prod_data};
  assign bias_ext = {{(ACC_W-DATA_W){bias_data[DATA_W-1]}}, bias_data};

  // Tap 0 starts from the bias instead of the running sum, which also covers TAPS==1.
  assign sum      = (is_first ? bias_ext : acc) + prod_ext;
  assign sum_wide = DEF_ACC_W'(sum);
  assign sat_res  = sat_to_data(sum_wide, DATA_W);

  // Only the final tap of a window needs FIFO space.
  assign ready_in   = !is_last || push_ready;
  assign accept     = valid_in && ready_in;
  assign push_valid = valid_in && is_last;
  assign push_entry = {(vox_cnt == LAST_VOX), sat_res.value[DATA_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      tap_cnt  <= '0;
      vox_cnt  <= '0;
      acc      <= '0;
      sat_flag <= 1'b0;
    end else if (accept) begin
      if (is_last) begin
        tap_cnt <= '0;
        acc     <= '0;
        vox_cnt <= (vox_cnt == LAST_VOX) ? '0 : vox_cnt + 1'b1;
        if (sat_res.ovf) sat_flag <= 1'b1;
      end else begin
        tap_cnt <= tap_cnt + 1'b1;
        acc     <= sum;
      end
    end
  end

  conv3d_skid_fifo2 #(
    .W(ENTRY_W)
  ) u_out_fifo (
    .clk        (clk),
    .rst        (rst_n),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_entry),
    .pop_valid  (valid_out),
    .pop_ready  (ready_out),
    .pop_data   (head_entry)
  );

  assign last_out    = head_entry[DATA_W];
  assign output_data = head_entry[DATA_W-1:0];

endmodule

// File: tb/tb_conv3d_tap_accumulator.sv
// Directed bench for conv3d_tap_accumulator: a TAPS=2 instance (dut_a) and a
// default TAPS=81 instance (dut_b) share clock and reset.
module tb_conv3d_tap_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          n_compared = 0;
  int          n_mismatched = 0;
  logic [31:0] exp_q[$];

  logic        a_valid_in = 1'b0, a_ready_in, a_valid_out, a_ready_out = 1'b1, a_last, a_sat;
  logic [31:0] a_prod = '0, a_bias = '0, a_data;
  logic        b_valid_in = 1'b0, b_ready_in, b_valid_out, b_ready_out = 1'b1, b_last, b_sat;
  logic [31:0] b_prod = '0, b_bias = '0, b_data;

  always #5 clk = ~clk;

  conv3d_tap_accumulator #(.KERNEL(1), .IN_CH(2)) dut_a (
    .clk(clk), .rst_n(rst), .valid_in(a_valid_in), .ready_in(a_ready_in),
    .prod_data(a_prod), .bias_data(a_bias), .valid_out(a_valid_out),
    .ready_out(a_ready_out), .output_data(a_data), .last_out(a_last), .sat_flag(a_sat)
  );

  conv3d_tap_accumulator dut_b (
    .clk(clk), .rst_n(rst), .valid_in(b_valid_in), .ready_in(b_ready_in),
    .prod_data(b_prod), .bias_data(b_bias), .valid_out(b_valid_out),
    .ready_out(b_ready_out), .output_data(b_data), .last_out(b_last), .sat_flag(b_sat)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    a_valid_in = 1'b0;
    b_valid_in = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One accepted tap on dut_a; returns 1 time unit after the accepting edge.
  task automatic a_send(input logic [31:0] bias, input logic [31:0] prod);
    logic rdy;
    int   guard;
    guard = 0;
    a_valid_in = 1'b1;
    a_bias = bias;
    a_prod = prod;
    forever begin
      @(negedge clk);
      rdy = a_ready_in;
      @(posedge clk); #1;
      if (rdy) break;
      guard++;
      if (guard > 500) begin
        n_compared++; n_mismatched++;
        $display("FAIL a_send_timeout: ready_in stayed %0b, required 1", a_ready_in);
        break;
      end
    end
    a_valid_in = 1'b0;
  endtask

  task automatic b_send(input logic [31:0] bias, input logic [31:0] prod);
    logic rdy;
    int   guard;
    guard = 0;
    b_valid_in = 1'b1;
    b_bias = bias;
    b_prod = prod;
    forever begin
      @(negedge clk);
      rdy = b_ready_in;
      @(posedge clk); #1;
      if (rdy) break;
      guard++;
      if (guard > 500) begin
        n_compared++; n_mismatched++;
        $display("FAIL b_send_timeout: ready_in stayed %0b, required 1", b_ready_in);
        break;
      end
    end
    b_valid_in = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    a_ready_out = 1'b1;
    b_ready_out = 1'b1;
    do_reset();
    n_compared++; if (a_valid_out !== 1'b0) begin n_mismatched++; $display("FAIL rst_a_valid: got %0b want 0", a_valid_out); end
    n_compared++; if (a_data !== 32'd0) begin n_mismatched++; $display("FAIL rst_a_data: got %h want 0", a_data); end
    n_compared++; if (a_last !== 1'b0) begin n_mismatched++; $display("FAIL rst_a_last: got %0b want 0", a_last); end
    n_compared++; if (a_sat !== 1'b0) begin n_mismatched++; $display("FAIL rst_a_sat: got %0b want 0", a_sat); end
    n_compared++; if (a_ready_in !== 1'b1) begin n_mismatched++; $display("FAIL rst_a_ready_in: got %0b want 1", a_ready_in); end
    n_compared++; if (b_valid_out !== 1'b0) begin n_mismatched++; $display("FAIL rst_b_valid: got %0b want 0", b_valid_out); end
    n_compared++; if (b_data !== 32'd0) begin n_mismatched++; $display("FAIL rst_b_data: got %h want 0", b_data); end
    n_compared++; if (b_ready_in !== 1'b1) begin n_mismatched++; $display("FAIL rst_b_ready_in: got %0b want 1", b_ready_in); end
  endtask

  task automatic test_basic();
    do_reset();
    a_ready_out = 1'b1;
    a_send(32'd5, 32'd10);
    n_compared++; if (a_valid_out !== 1'b0) begin n_mismatched++; $display("FAIL basic_mid_valid: got %0b want 0", a_valid_out); end
    a_send(32'd0, -32'sd3);
    n_compared++; if (a_valid_out !== 1'b1) begin n_mismatched++; $display("FAIL basic_valid: got %0b want 1", a_valid_out); end
    n_compared++; if (a_data !== 32'd12) begin n_mismatched++; $display("FAIL basic_data: got %0d want 12", a_data); end
    n_compared++; if (a_last !== 1'b0) begin n_mismatched++; $display("FAIL basic_last: got %0b want 0", a_last); end
    @(posedge clk); #1;
    n_compared++; if (a_valid_out !== 1'b0) begin n_mismatched++; $display("FAIL basic_one_cycle: got %0b want 0", a_valid_out); end
    n_compared++; if (a_data !== 32'd12) begin n_mismatched++; $display("FAIL basic_hold: got %0d want 12", a_data); end
    n_compared++; if (a_sat !== 1'b0) begin n_mismatched++; $display("FAIL basic_sat: got %0b want 0", a_sat); end
  endtask

  task automatic test_default_stream();
    int results;
    do_reset();
    b_ready_out = 1'b1;
    results = 0;
    b_bias = 32'd0;
    b_prod = 32'd1;
    b_valid_in = 1'b1;
    for (int i = 0; i < 17 * 81; i++) begin
      @(negedge clk);
      if (b_ready_in !== 1'b1) begin
        n_compared++; n_mismatched++;
        $display("FAIL stream_ready_in tap %0d: got %0b want 1", i, b_ready_in);
      end
      @(posedge clk); #1;
      if (b_valid_out) begin
        n_compared++; if (b_data !== 32'd81) begin n_mismatched++; $display("FAIL stream_data #%0d: got %0d want 81", results, b_data); end
        n_compared++; if (b_last !== (results == 15)) begin n_mismatched++; $display("FAIL stream_last #%0d: got %0b want %0b", results, b_last, results == 15); end
        results++;
      end
    end
    b_valid_in = 1'b0;
    n_compared++; if (results != 17) begin n_mismatched++; $display("FAIL stream_count: got %0d want 17", results); end
  endtask

  task automatic test_saturation();
    do_reset();
    a_ready_out = 1'b1;
    a_send(32'd1, 32'h7FFF_FFFF);
    n_compared++; if (a_sat !== 1'b0) begin n_mismatched++; $display("FAIL sat_early: got %0b want 0", a_sat); end
    a_send(32'd0, 32'h7FFF_FFFF);
    n_compared++; if (a_data !== 32'h7FFF_FFFF) begin n_mismatched++; $display("FAIL sat_pos_data: got %h want 7fffffff", a_data); end
    n_compared++; if (a_sat !== 1'b1) begin n_mismatched++; $display("FAIL sat_pos_flag: got %0b want 1", a_sat); end
    a_send(32'd0, 32'h8000_0000);
    a_send(32'd0, 32'h8000_0000);
    n_compared++; if (a_data !== 32'h8000_0000) begin n_mismatched++; $display("FAIL sat_neg_data: got %h want 80000000", a_data); end
    n_compared++; if (a_sat !== 1'b1) begin n_mismatched++; $display("FAIL sat_sticky: got %0b want 1", a_sat); end
  endtask

  task automatic test_backpressure();
    do_reset();
    a_ready_out = 1'b0;
    a_send(32'd1, 32'd2);
    a_send(32'd0, 32'd3);
    a_send(32'd10, 32'd20);
    a_send(32'd0, 32'd30);
    n_compared++; if (a_data !== 32'd6 || a_valid_out !== 1'b1) begin n_mismatched++; $display("FAIL bp_head: got %0d/%0b want 6/1", a_data, a_valid_out); end
    n_compared++; if (a_ready_in !== 1'b1) begin n_mismatched++; $display("FAIL bp_nonfinal_ready: got %0b want 1", a_ready_in); end
    a_send(-32'sd5, -32'sd6);
    a_valid_in = 1'b1;
    a_prod = -32'sd7;
    #1;
    n_compared++; if (a_ready_in !== 1'b0) begin n_mismatched++; $display("FAIL bp_final_stall: got %0b want 0", a_ready_in); end
    repeat (3) begin
      @(posedge clk); #1;
      n_compared++; if (a_ready_in !== 1'b0) begin n_mismatched++; $display("FAIL bp_stall_hold: got %0b want 0", a_ready_in); end
      n_compared++; if (a_data !== 32'd6) begin n_mismatched++; $display("FAIL bp_data_stable: got %0d want 6", a_data); end
    end
    a_ready_out = 1'b1;
    #1;
    n_compared++; if (a_ready_in !== 1'b1) begin n_mismatched++; $display("FAIL bp_ready_on_pop: got %0b want 1", a_ready_in); end
    @(posedge clk); #1;
    a_valid_in = 1'b0;
    n_compared++; if (a_data !== 32'd60 || a_valid_out !== 1'b1) begin n_mismatched++; $display("FAIL bp_drain2: got %0d/%0b want 60/1", a_data, a_valid_out); end
    @(posedge clk); #1;
    n_compared++; if (a_data !== 32'hFFFF_FFEE || a_valid_out !== 1'b1) begin n_mismatched++; $display("FAIL bp_drain3: got %h/%0b want ffffffee/1", a_data, a_valid_out); end
    @(posedge clk); #1;
    n_compared++; if (a_valid_out !== 1'b0) begin n_mismatched++; $display("FAIL bp_empty: got %0b want 0", a_valid_out); end
    n_compared++; if (a_data !== 32'hFFFF_FFEE) begin n_mismatched++; $display("FAIL bp_empty_hold: got %h want ffffffee", a_data); end
  endtask

  task automatic test_reset_midwindow();
    do_reset();
    b_ready_out = 1'b0;
    for (int i = 0; i < 81; i++) b_send(32'd0, 32'd1);
    n_compared++; if (b_valid_out !== 1'b1 || b_data !== 32'd81) begin n_mismatched++; $display("FAIL mid_buffered: got %0d/%0b want 81/1", b_data, b_valid_out); end
    for (int i = 0; i < 40; i++) b_send(32'd0, 32'd100);
    do_reset();
    n_compared++; if (b_valid_out !== 1'b0) begin n_mismatched++; $display("FAIL mid_rst_valid: got %0b want 0", b_valid_out); end
    n_compared++; if (b_data !== 32'd0) begin n_mismatched++; $display("FAIL mid_rst_data: got %0d want 0", b_data); end
    b_ready_out = 1'b1;
    b_send(32'd7, 32'd2);
    for (int i = 1; i < 81; i++) b_send(32'd0, 32'd2);
    n_compared++; if (b_valid_out !== 1'b1) begin n_mismatched++; $display("FAIL mid_next_valid: got %0b want 1", b_valid_out); end
    n_compared++; if (b_data !== 32'd169) begin n_mismatched++; $display("FAIL mid_next_data: got %0d want 169", b_data); end
    n_compared++; if (b_last !== 1'b0) begin n_mismatched++; $display("FAIL mid_next_last: got %0b want 0", b_last); end
    @(posedge clk); #1;
    n_compared++; if (b_valid_out !== 1'b0) begin n_mismatched++; $display("FAIL mid_no_residue: got %0b want 0", b_valid_out); end
  endtask

  task automatic test_random_gaps();
    int          got;
    int          cyc;
    logic        stalled;
    logic [31:0] held;
    logic [31:0] e;
    do_reset();
    exp_q.delete();
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    fork
      begin
        int b, p0, p1;
        for (int w = 0; w < 10; w++) begin
          b  = int'($urandom_range(0, 2000)) - 1000;
          p0 = int'($urandom_range(0, 2000)) - 1000;
          p1 = int'($urandom_range(0, 2000)) - 1000;
          exp_q.push_back(32'(b + p0 + p1));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          a_send(32'(b), 32'(p0));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          a_send(32'd0, 32'(p1));
        end
      end
      begin
        while (got < 10 && cyc < 3000) begin
          @(posedge clk); #2;
          cyc++;
          if (stalled) begin
            n_compared++;
            if (a_valid_out !== 1'b1 || a_data !== held) begin
              n_mismatched++;
              $display("FAIL rnd_stable: got %h/%0b want %h/1", a_data, a_valid_out, held);
            end
          end
          a_ready_out = 1'($urandom_range(0, 1));
          if (a_valid_out && a_ready_out) begin
            got++;
            stalled = 1'b0;
            n_compared++;
            if (exp_q.size() == 0) begin
              n_mismatched++;
              $display("FAIL rnd_extra: got %h want none", a_data);
            end else begin
              e = exp_q.pop_front();
              if (a_data !== e) begin
                n_mismatched++;
                $display("FAIL rnd_data #%0d: got %h want %h", got - 1, a_data, e);
              end
            end
          end else begin
            stalled = a_valid_out;
            held = a_data;
          end
        end
        n_compared++;
        if (got != 10) begin n_mismatched++; $display("FAIL rnd_timeout: got %0d results want 10", got); end
      end
    join
    a_ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_compared++; if (a_valid_out !== 1'b0) begin n_mismatched++; $display("FAIL rnd_dup: valid_out %0b want 0", a_valid_out); end
    n_compared++; if (exp_q.size() != 0) begin n_mismatched++; $display("FAIL rnd_lost: %0d left want 0", exp_q.size()); end
    n_compared++; if (a_sat !== 1'b0) begin n_mismatched++; $display("FAIL rnd_sat: got %0b want 0", a_sat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_default_stream();
    test_saturation();
    test_backpressure();
    test_reset_midwindow();
    test_random_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
